pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Consumer end of the CC_PLL lock interface. Synchronises the PLL lock flags into the free-running reference clock domain. Drives the steady-lock clear pulse back into the PLL. Releases a clean reset to the PLL-clocked logic only after lock has been stable for a programmable time, and counts lock-loss events for debug and LED reporting.

Parameters:
STABLE_CYCLES, 1024, consecutive good-lock cycles required before release; must be >= 2
STDY_RST_CYCLES, 16, length in cycles of the stdy_rst_o pulse; must be >= 1
LOSS_CNT_W, 8, width of the saturating lock-loss counter
SYNC_STAGES, 2, flip-flop stages on each asynchronous lock input; must be >= 2

Ports:
clk_i  in  1  free-running board reference clock (same net as the PLL CLK_REF)
rst_i  in  1  synchronous, active-high reset
pll_lock_i  in  1  PLL USR_PLL_LOCKED; asynchronous to clk_i
pll_lock_stdy_i  in  1  PLL USR_PLL_LOCKED_STDY; asynchronous to clk_i
stdy_rst_o  out  1  active-high clear for the PLL steady-lock latch; the integrator inverts it if required
domain_rst_o  out  1  active-high reset for logic clocked by the PLL output; the consumer re-synchronises it
ready_o  out  1  high while the PLL is considered stably locked
loss_cnt_o  out  LOSS_CNT_W  number of lock losses seen while in RUN; saturating
state_o  out  2  current FSM state, for debug

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Input synchronisers: lock_s and stdy_s are the outputs of SYNC_STAGES-deep synchronisers on the two lock inputs. Define good = lock_s & stdy_s.
- FSM states: CLEAR=0, WAIT_LOCK=1, STABLE=2, RUN=3. All outputs are registered or decoded directly from the state register.
- Reset values: state CLEAR, clear counter 0, stable counter 0, loss_cnt_o 0, stdy_rst_o 1, domain_rst_o 1, ready_o 0. Synchroniser flops reset to 0.
- CLEAR:
  - stdy_rst_o is 1.
  - Stays exactly STDY_RST_CYCLES cycles, then moves to WAIT_LOCK.
  - Lock inputs are ignored.
- WAIT_LOCK:
  - If good, move to STABLE and clear the stable counter.
  - Otherwise remain in WAIT_LOCK.
- STABLE:
  - If !good, return to WAIT_LOCK. This is not a loss event.
  - Else if the stable counter equals STABLE_CYCLES-1, move to RUN.
  - Otherwise increment the stable counter.
  - STABLE therefore lasts STABLE_CYCLES cycles.
- RUN:
  - On !good: loss_cnt_o increments, saturating at 2^LOSS_CNT_W-1, and the FSM moves to CLEAR on the same edge.
  - Otherwise remain in RUN.
- Output decode:
  - stdy_rst_o = (state == CLEAR)
  - ready_o = (state == RUN)
  - domain_rst_o = (state != RUN)
  - ready_o and domain_rst_o are always complementary.
- Latency: with both lock inputs held high, ready_o rises SYNC_STAGES + 1 + STABLE_CYCLES edges after the first edge that samples them high. The measurement starts in WAIT_LOCK.
- Loss latency: after good falls in RUN, domain_rst_o rises SYNC_STAGES + 1 edges after the input falls.
- Boundaries:
  - A glitch in STABLE restarts qualification from WAIT_LOCK.
  - Glitches shorter than one cycle may be missed; no pulse stretching is applied.
  - A drop of stdy alone counts as a loss.
  - Saturation at all-ones holds; there is no wrap.
- rst_i mid-operation: immediate return to the reset values, including clearing loss_cnt_o. rst_i has priority over every transition.
- Counter widths: the stable counter is $clog2(STABLE_CYCLES) bits and the clear counter is $clog2(STDY_RST_CYCLES+1) bits. Counters never overflow.

Decomposition:
- Package pll_sup_pkg holds:
  - the 2-bit state enum (CLEAR, WAIT_LOCK, STABLE, RUN);
  - default constants for STABLE_CYCLES and STDY_RST_CYCLES.
- One sub-module, cdc_sync_bit:
  - parameter STAGES, ports clk_i, rst_i, d_i, q_o;
  - instantiated once per lock input.

Test Plan:
1. Reset, then both inputs held at 1 with STABLE_CYCLES=8 and STDY_RST_CYCLES=4:
   - stdy_rst_o is high for exactly 4 cycles after reset;
   - ready_o rises 2+1+8=11 edges into WAIT_LOCK;
   - domain_rst_o falls on the same edge;
   - loss_cnt_o stays 0.
2. Lock dropped for 3 cycles midway through STABLE:
   - state returns to WAIT_LOCK and ready_o does not rise early;
   - qualification restarts on relock;
   - loss_cnt_o stays 0.
3. In RUN, pll_lock_i dropped for 5 cycles:
   - domain_rst_o goes to 1 and ready_o to 0, 3 edges after the drop;
   - loss_cnt_o = 1;
   - stdy_rst_o pulses for 4 cycles;
   - re-qualification follows once lock returns.
4. In RUN, only pll_lock_stdy_i dropped:
   - treated as a loss, loss_cnt_o increments, and the CLEAR pulse is issued.
5. LOSS_CNT_W=2, five loss events:
   - loss_cnt_o reads 1, 2, 3, 3, 3.
6. rst_i asserted for 1 cycle while in RUN with loss_cnt_o = 2:
   - next cycle state = CLEAR, loss_cnt_o = 0, stdy_rst_o = 1, domain_rst_o = 1.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// Holds the FSM state encoding and the default qualification timings.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int DEF_STABLE_CYCLES   = 1024;
    localparam int DEF_STDY_RST_CYCLES = 16;

endpackage : pll_sup_pkg

// File: rtl/pll_lock_supervisor_sync.sv
// Multi-stage single-bit synchroniser for slow level signals crossing into clk_i.
// Not suitable for pulses shorter than one clk_i period.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: non-blocking assignment keeps every stage sampling the previous
    // value of its neighbour, so the chain really is STAGES flops deep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL lock flags, pulses the steady-lock clear and gates the
// PLL-domain reset; also counts lock losses seen while running.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int STDY_RST_CYCLES = DEF_STDY_RST_CYCLES,
    parameter int LOSS_CNT_W      = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_lock_i,
    input  logic                  pll_lock_stdy_i,
    output logic                  stdy_rst_o,
    output logic                  domain_rst_o,
    output logic                  ready_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o,
    output logic [1:0]            state_o
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int CW = $clog2(STDY_RST_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LAST  = CW'(STDY_RST_CYCLES - 1);

    logic lock_s;
    logic stdy_s;
    logic good;

    pll_state_e            state;
    logic [CW-1:0]         clr_cnt;
    logic [SW-1:0]         stable_cnt;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_stdy (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_stdy_i),
        .q_o   (stdy_s)
    );

    assign good = lock_s & stdy_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            stable_cnt <= '0;
            loss_cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    // Lock flags are ignored while the steady latch is held in clear.
                    if (clr_cnt == CLEAR_LAST) begin
                        clr_cnt <= '0;
                        state   <= WAIT_LOCK;
                    end else begin
                        clr_cnt <= clr_cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (good) begin
                        stable_cnt <= '0;
                        state      <= STABLE;
                    end
                end
                STABLE: begin
                    if (!good) begin
                        state <= WAIT_LOCK;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state <= RUN;
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end
                RUN: begin
                    if (!good) begin
                        if (loss_cnt != '1) begin
                            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
                        end
                        state <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Outputs decode straight from the state register, so they change only on clk_i edges.
    assign stdy_rst_o   = (state == CLEAR);
    assign ready_o      = (state == RUN);
    assign domain_rst_o = (state != RUN);
    assign loss_cnt_o   = loss_cnt;
    assign state_o      = state;

endmodule : pll_lock_supervisor

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a behavioural model predicts every
// cycle's outputs; a separate monitor compares them on the falling edge.
module tb_pll_lock_supervisor;

    localparam int SS  = 2;
    localparam int SC  = 8;
    localparam int SR  = 4;
    localparam int LW  = 2;
    localparam int MAX_LOSS = (1 << LW) - 1;

    typedef struct {
        logic [1:0]    st;
        logic          stdy_rst;
        logic          dom_rst;
        logic          ready;
        logic [LW-1:0] loss;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          pll_lock;
    logic          pll_stdy;
    logic          stdy_rst;
    logic          domain_rst;
    logic          ready;
    logic [LW-1:0] loss_cnt;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb_q[$];

    pll_lock_supervisor #(
        .STABLE_CYCLES   (SC),
        .STDY_RST_CYCLES (SR),
        .LOSS_CNT_W      (LW),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pll_lock_i      (pll_lock),
        .pll_lock_stdy_i (pll_stdy),
        .stdy_rst_o      (stdy_rst),
        .domain_rst_o    (domain_rst),
        .ready_o         (ready),
        .loss_cnt_o      (loss_cnt),
        .state_o         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: CLEAR is a countdown, qualification is a run of
    // consecutive good samples (one to leave WAIT_LOCK plus SC in STABLE).
    int         clear_left = SR;
    int         streak     = 0;
    bit         running    = 1'b0;
    int         loss_m     = 0;
    bit [SS-1:0] lock_dl   = '0;
    bit [SS-1:0] stdy_dl   = '0;

    always @(posedge clk) begin
        exp_t e;
        bit   good_m;
        if (rst) begin
            clear_left = SR;
            streak     = 0;
            running    = 1'b0;
            loss_m     = 0;
            lock_dl    = '0;
            stdy_dl    = '0;
        end else begin
            good_m = lock_dl[SS-1] & stdy_dl[SS-1];
            if (clear_left > 0) begin
                clear_left--;
            end else if (running) begin
                if (!good_m) begin
                    running    = 1'b0;
                    loss_m     = (loss_m == MAX_LOSS) ? MAX_LOSS : loss_m + 1;
                    clear_left = SR;
                end
            end else begin
                streak = good_m ? streak + 1 : 0;
                if (streak == SC + 1) begin
                    running = 1'b1;
                    streak  = 0;
                end
            end
            lock_dl = {lock_dl[SS-2:0], pll_lock};
            stdy_dl = {stdy_dl[SS-2:0], pll_stdy};
        end
        e.st       = (clear_left > 0) ? 2'd0 : running ? 2'd3 : (streak > 0) ? 2'd2 : 2'd1;
        e.stdy_rst = (clear_left > 0);
        e.ready    = running;
        e.dom_rst  = !running;
        e.loss     = LW'(loss_m);
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("state",      32'(state),      32'(e.st));
            check("stdy_rst",   32'(stdy_rst),   32'(e.stdy_rst));
            check("domain_rst", 32'(domain_rst), 32'(e.dom_rst));
            check("ready",      32'(ready),      32'(e.ready));
            check("loss_cnt",   32'(loss_cnt),   32'(e.loss));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        check(name, 32'(ready), 32'd1);
    endtask

    task automatic drop(input bit which_stdy, input int n);
        if (which_stdy) pll_stdy = 1'b0;
        else            pll_lock = 1'b0;
        cycles(n);
        pll_lock = 1'b1;
        pll_stdy = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] sat_seq [5];
        sat_seq[0] = 2'd1;
        sat_seq[1] = 2'd2;
        sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3;
        sat_seq[4] = 2'd3;

        rst      = 1'b1;
        pll_lock = 1'b1;
        pll_stdy = 1'b1;
        cycles(3);

        // Power-up qualification with both flags steady.
        rst = 1'b0;
        wait_ready("t1_run", 40);
        cycles(3);

        // Lock drop while running: loss, clear pulse, re-qualification.
        drop(1'b0, 5);
        wait_ready("t3_requal", 60);
        cycles(3);

        // Only the steady flag drops.
        drop(1'b1, 3);
        wait_ready("t4_requal", 60);
        cycles(2);
        check("loss_before_rst", 32'(loss_cnt), 32'd2);

        // One-cycle reset in RUN.
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("rst_loss_clear", 32'(loss_cnt), 32'd0);

        // Glitch mid-qualification (CLEAR 4 + sync, then a few STABLE cycles).
        cycles(8);
        drop(1'b0, 3);
        wait_ready("t2_requal", 60);
        cycles(2);

        // Saturation of the loss counter.
        for (int k = 0; k < 5; k++) begin
            drop(k[0], 4);
            wait_ready("t5_requal", 60);
            check("t5_loss_sat", 32'(loss_cnt), 32'(sat_seq[k]));
            cycles(2);
        end

        // Randomised flag activity with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            rst      = ($urandom_range(0, 99) < 3);
            pll_lock = ($urandom_range(0, 9) != 0);
            pll_stdy = ($urandom_range(0, 9) != 0);
            if (rst) begin
                cycles(1);
                rst = 1'b0;
            end
            cycles($urandom_range(1, 25));
        end

        cycles(2);
        check("sb_drain", 32'(sb_q.size() <= 1), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pll_lock_supervisor
